// File: rtl/jzjpcc_fetch_pkg.sv
// ============================================================================
// Module      : jzjpcc_fetch_pkg
// Description : Shared fetch-path constants and types for the instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jzjpcc_fetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } inst_mem_state_t;

  typedef logic [31:2] word_addr_t;

endpackage

`default_nettype wire

// File: rtl/jzjpcc_inst_sram.sv
// ============================================================================
// Module      : jzjpcc_inst_sram
// Description : Single-port instruction RAM: synchronous write, unregistered
//               read of an externally registered index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_inst_sram #(
  parameter int DEPTH_WORDS = 2048,
  parameter int INDEX_BITS  = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [31:0]           write_data,
  input  logic [INDEX_BITS-1:0] read_index,
  output logic [31:0]           read_data
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      r_mem[write_index] <= write_data;
    end
  end

  assign read_data = r_mem[read_index];

endmodule

`default_nettype wire

// File: rtl/jzjpcc_inst_mem.sv
// ============================================================================
// Module      : jzjpcc_inst_mem
// Description : Instruction-memory responder with registered fetch address,
//               flush/stall bubble handling and a streaming program-load port.
//               Optional JZJPCC_INST_MEM_BOUNDS_CHECK_EN adds out-of-range
//               detection with a sticky instAccessFault output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_inst_mem #(
  parameter int          MEM_DEPTH_WORDS = 2048,
  parameter logic [31:0] NOP_WORD        = jzjpcc_fetch_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_fetch,
  input  logic        flush_fetch,
  input  logic [31:2] nextPC,
  output logic [31:0] instruction_fetch,
  output logic        instructionValid_fetch,
  input  logic        loadStart,
  input  logic [31:2] loadBaseAddress,
  input  logic [31:0] loadData,
  input  logic        loadValid,
  output logic        loadReady,
  input  logic        loadLast,
  output logic        holdCore
`ifdef JZJPCC_INST_MEM_BOUNDS_CHECK_EN
  ,
  output logic        instAccessFault
`endif
);

  import jzjpcc_fetch_pkg::*;

  localparam int c_INDEX_BITS = $clog2(MEM_DEPTH_WORDS);

  inst_mem_state_t           r_state;
  inst_mem_state_t           w_state_next;
  logic [c_INDEX_BITS-1:0]   r_addr_reg;
  logic                      r_bubble;
  logic                      w_load_ready;
  logic                      w_hold_core;
  logic                      w_load_fire;
  logic                      w_write_enable;
  logic                      w_fetch_bubble;
  logic [c_INDEX_BITS-1:0]   w_write_index;
  logic [31:0]               w_read_data;

`ifdef JZJPCC_INST_MEM_BOUNDS_CHECK_EN
  word_addr_t                r_load_ptr;
  logic                      r_addr_oob;
  logic                      r_access_fault;
  logic                      w_ptr_oob;

  assign w_ptr_oob      = |r_load_ptr[31:2+c_INDEX_BITS];
  assign w_write_index  = r_load_ptr[c_INDEX_BITS+1:2];
  assign w_write_enable = w_load_fire && !w_ptr_oob;
`else
  logic [c_INDEX_BITS-1:0]   r_load_ptr;
  logic                      w_unused_upper_bits;

  // Upper address bits are don't-care: accesses wrap within the array.
  assign w_unused_upper_bits = ^{nextPC[31:2+c_INDEX_BITS], loadBaseAddress[31:2+c_INDEX_BITS]};
  assign w_write_index       = r_load_ptr;
  assign w_write_enable      = w_load_fire;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load_ready = 1'b0;
    w_hold_core  = 1'b0;
    w_load_fire  = 1'b0;
    case (r_state)
      RUN: begin
        if (loadStart) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_load_ready = 1'b1;
        w_hold_core  = 1'b1;
        w_load_fire  = loadValid;
        if (loadValid && loadLast) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_hold_core  = 1'b1;
        w_state_next = RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch address register; DRAIN parks it on the reset vector for restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr_reg <= '0;
    end else if (r_state == DRAIN) begin
      r_addr_reg <= '0;
    end else if (!stall_fetch && !w_hold_core) begin
      r_addr_reg <= nextPC[c_INDEX_BITS+1:2];
    end
  end

  // A flush seen while stalled must survive until the stall releases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bubble <= 1'b0;
    end else if (r_state == DRAIN) begin
      r_bubble <= 1'b0;
    end else if (stall_fetch) begin
      r_bubble <= r_bubble | flush_fetch;
    end else begin
      r_bubble <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_load_ptr <= '0;
    end else if ((r_state == RUN) && loadStart) begin
`ifdef JZJPCC_INST_MEM_BOUNDS_CHECK_EN
      r_load_ptr <= loadBaseAddress;
`else
      r_load_ptr <= loadBaseAddress[c_INDEX_BITS+1:2];
`endif
    end else if (w_load_fire) begin
      r_load_ptr <= r_load_ptr + 1'b1;
    end
  end

`ifdef JZJPCC_INST_MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr_oob     <= 1'b0;
      r_access_fault <= 1'b0;
    end else begin
      if (r_state == DRAIN) begin
        r_addr_oob <= 1'b0;
      end else if (!stall_fetch && !w_hold_core) begin
        r_addr_oob <= |nextPC[31:2+c_INDEX_BITS];
      end
      if (r_addr_oob || (w_load_fire && w_ptr_oob)) begin
        r_access_fault <= 1'b1;
      end
    end
  end

  assign instAccessFault = r_access_fault;
  assign w_fetch_bubble  = r_bubble || flush_fetch || (r_state == LOAD) || r_addr_oob;
`else
  assign w_fetch_bubble  = r_bubble || flush_fetch || (r_state == LOAD);
`endif

  jzjpcc_inst_sram #(
    .DEPTH_WORDS (MEM_DEPTH_WORDS),
    .INDEX_BITS  (c_INDEX_BITS)
  ) u_sram (
    .clock        (clock),
    .write_enable (w_write_enable),
    .write_index  (w_write_index),
    .write_data   (loadData),
    .read_index   (r_addr_reg),
    .read_data    (w_read_data)
  );

  assign instruction_fetch      = w_fetch_bubble ? NOP_WORD : w_read_data;
  assign instructionValid_fetch = !w_fetch_bubble;
  assign loadReady              = w_load_ready;
  assign holdCore               = w_hold_core;

endmodule

`default_nettype wire
